stack_core: RTL and testbench
=============================

STACK_CORE -- requirements
Module: stack_core

Interface
REQ-001 Parameter DATA_W, default 16: width of instruction words, stack entries and ALU results.
REQ-002 Parameter ADDR_W, default 16: width of the ROM address, RAM address and pc.
REQ-003 Parameter STACK_DEPTH, default 256: maximum number of stack entries, including TOS (top of stack).
REQ-004 Parameter STACK_BASE, default 0: RAM address of stack entry 0.
REQ-005 Port clock, input, 1 bit: the only clock; all registers update on its rising edge.
REQ-006 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port run, input, 1 bit: when low, the core stalls in FETCH.
REQ-008 Ports address_rom (output, ADDR_W) and q_rom (input, DATA_W): synchronous ROM; q_rom is valid one cycle after the address is presented.
REQ-009 Ports address_ram (output, ADDR_W), q_ram (input, DATA_W), data_ram (output, DATA_W), wren_ram (output, 1): synchronous RAM with 1-cycle read latency; a write occurs on any edge where wren_ram is high.
REQ-010 Status outputs: pc (ADDR_W), state (4 bits), depth ($clog2(STACK_DEPTH+1) bits), tos (DATA_W), halted (1), error (1), err_code (2 bits).

Function
REQ-011 The core SHALL hold TOS in a register; entries below TOS SHALL live in RAM at STACK_BASE+i, for i = 0..depth-2.
REQ-012 The opcode SHALL be q_rom[7:0] and upper bits SHALL be ignored. Opcodes: HALT 0x00, IMM 0x01, JMP 0x06, JZ 0x07, ADD 0x0b, SUB 0x0c, AND 0x0d, OR 0x0e, XOR 0x0f, DUP 0x10, DROP 0x11, NOP 0x18.
REQ-013 States SHALL be FETCH, DECODE, OP_WAIT, OPERAND, RD_WAIT, EXEC, HALTED, ERROR.
REQ-014 address_rom SHALL equal pc at all times.
REQ-015 FETCH: if run=1, go to DECODE; otherwise hold.
REQ-016 DECODE: latch the opcode. NOP and DUP: pc+1, then FETCH (2 cycles). HALT: go to HALTED.
REQ-017 IMM, JMP and JZ SHALL take 4 cycles: FETCH, DECODE (pc+1), OP_WAIT, OPERAND (q_rom = operand).
- IMM: push the operand, pc+1.
- JMP: pc <= operand.
- JZ: pop; pc <= operand if the old TOS == 0, else pc+1.
REQ-018 Binary ops and DROP SHALL take 4 cycles: FETCH, DECODE (address_ram <= STACK_BASE+depth-2), RD_WAIT, EXEC.
- Binary ops: tos <= q_ram OP tos (SUB = NOS-TOS); depth-1; pc+1.
- DROP: tos <= q_ram; depth-1; pc+1.
REQ-019 JZ SHALL issue its TOS-refill read in DECODE and consume q_ram in OPERAND.
REQ-020 A push (IMM, DUP) with depth>=1 SHALL write the old TOS to STACK_BASE+depth-1, with wren_ram high for exactly one cycle; with depth=0 it SHALL write nothing.
REQ-021 Arithmetic SHALL be modulo 2^DATA_W with no flags.
REQ-022 pc SHALL wrap from 2^ADDR_W-1 to 0.
REQ-023 Overflow: a push at depth==STACK_DEPTH SHALL enter ERROR with err_code=1. No write occurs and depth is unchanged.
REQ-024 Underflow: a binary op at depth<2, or DROP/JZ/DUP at depth<1, SHALL enter ERROR with err_code=2.
REQ-025 An undefined opcode SHALL enter ERROR with err_code=3.
REQ-026 ERROR and HALTED SHALL be sticky until reset; error/halted SHALL be high only in those states; wren_ram=0 there.
REQ-027 wren_ram SHALL never be high outside the single write cycle of a push.

Reset
REQ-028 While reset_n=0, asynchronously: pc=0, state=FETCH, depth=0, tos=0, wren_ram=0, address_ram=0, data_ram=0, err_code=0, halted=0, error=0.
REQ-029 Reset asserted mid-instruction SHALL abort it without any RAM write. Execution SHALL restart at pc 0 on the first edge after deassertion.

Structure
REQ-030 Package stack_core_pkg SHALL hold the opcode enum, the state enum and the err_code constants.
REQ-031 Combinational sub-module stack_alu (op, a, b, result; DATA_W parameter) SHALL implement ADD/SUB/AND/OR/XOR.
REQ-032 Total RTL SHALL stay within 120-400 lines.

Verification
REQ-033 ROM {IMM 3, IMM 5, ADD, HALT} -> tos=8, depth=1, halted=1 after 14 cycles; exactly one wren_ram pulse, writing 3 to RAM[0].
REQ-034 ROM {IMM 2, IMM 7, SUB, HALT} -> tos=0xFFFB, depth=1.
REQ-035 ROM {IMM 0, JZ 0x10}, with HALT at 0x10 -> pc=0x10, depth=0, halted=1; repeat with IMM 1 -> HALT reached at pc=4.
REQ-036 STACK_DEPTH=4, five IMMs -> ERROR with err_code=1 after the fifth OPERAND; depth=4; RAM[3] not written.
REQ-037 ADD at pc 0 after reset -> ERROR with err_code=2; opcode 0x55 -> ERROR with err_code=3; run=0 -> pc stays 0 indefinitely.
REQ-038 reset_n pulsed low during RD_WAIT of ADD -> all outputs reset immediately with no write; the program reruns from pc 0 to the same final tos.

Source files
------------

// File: rtl/stack_core_pkg.sv
// Shared definitions for the stack_core processor: opcode and FSM state
// enumerations, error-code constants and an opcode classification helper.
package stack_core_pkg;

  typedef enum logic [7:0] {
    OP_HALT = 8'h00,
    OP_IMM  = 8'h01,
    OP_JMP  = 8'h06,
    OP_JZ   = 8'h07,
    OP_ADD  = 8'h0b,
    OP_SUB  = 8'h0c,
    OP_AND  = 8'h0d,
    OP_OR   = 8'h0e,
    OP_XOR  = 8'h0f,
    OP_DUP  = 8'h10,
    OP_DROP = 8'h11,
    OP_NOP  = 8'h18
  } opcode_t;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_OP_WAIT = 4'd2,
    ST_OPERAND = 4'd3,
    ST_RD_WAIT = 4'd4,
    ST_EXEC    = 4'd5,
    ST_HALTED  = 4'd6,
    ST_ERROR   = 4'd7
  } state_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

  function automatic logic is_binop(input logic [7:0] op);
    return (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR});
  endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational ALU for the two-operand stack instructions.
// Ports: op     - opcode byte (ADD/SUB/AND/OR/XOR)
//        a      - next-on-stack operand
//        b      - top-of-stack operand
//        result - a OP b, modulo 2^DATA_W (SUB is a - b)
module stack_alu
  import stack_core_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [7:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/stack_core.sv
// Multi-cycle stack processor. TOS is held in a register; deeper entries live
// in an external synchronous RAM at STACK_BASE+i. Instructions come from a
// synchronous ROM addressed directly by pc.
// Ports: clock, reset_n (async active-low), run (stall in FETCH when low)
//        address_rom/q_rom                     - instruction ROM
//        address_ram/q_ram/data_ram/wren_ram   - stack RAM
//        pc, state, depth, tos, halted, error, err_code - status
module stack_core
  import stack_core_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 256,
  parameter int STACK_BASE  = 0
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               run,
  output logic [ADDR_W-1:0]                  address_rom,
  input  logic [DATA_W-1:0]                  q_rom,
  output logic [ADDR_W-1:0]                  address_ram,
  input  logic [DATA_W-1:0]                  q_ram,
  output logic [DATA_W-1:0]                  data_ram,
  output logic                               wren_ram,
  output logic [ADDR_W-1:0]                  pc,
  output logic [3:0]                         state,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic [DATA_W-1:0]                  tos,
  output logic                               halted,
  output logic                               error,
  output logic [1:0]                         err_code
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);
  localparam logic [ADDR_W-1:0]  BASE = ADDR_W'(STACK_BASE);

  state_t              r_state,    w_state_nxt;
  logic [ADDR_W-1:0]   r_pc,       w_pc_nxt;
  logic [DEPTH_W-1:0]  r_depth,    w_depth_nxt;
  logic [DATA_W-1:0]   r_tos,      w_tos_nxt;
  logic [7:0]          r_op,       w_op_nxt;
  logic [ADDR_W-1:0]   r_addr_ram, w_addr_nxt;
  logic [DATA_W-1:0]   r_data_ram, w_data_nxt;
  logic                r_wren,     w_wren_nxt;
  logic [1:0]          r_err_code, w_err_nxt;

  logic [ADDR_W-1:0]   w_top_addr;  // slot the current TOS spills to on a push
  logic [ADDR_W-1:0]   w_nos_addr;  // slot holding the entry just below TOS
  logic [DATA_W-1:0]   w_alu;

  assign w_top_addr = BASE + ADDR_W'(r_depth) - ADDR_W'(1);
  assign w_nos_addr = BASE + ADDR_W'(r_depth) - ADDR_W'(2);

  stack_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (r_op),
    .a      (q_ram),
    .b      (r_tos),
    .result (w_alu)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_FETCH;
      r_pc       <= '0;
      r_depth    <= '0;
      r_tos      <= '0;
      r_op       <= '0;
      r_addr_ram <= '0;
      r_data_ram <= '0;
      r_wren     <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_depth    <= w_depth_nxt;
      r_tos      <= w_tos_nxt;
      r_op       <= w_op_nxt;
      r_addr_ram <= w_addr_nxt;
      r_data_ram <= w_data_nxt;
      r_wren     <= w_wren_nxt;
      r_err_code <= w_err_nxt;
    end
  end

  // Push writes are registered: the spill of the old TOS is set up here and
  // lands in RAM on the following edge, so wren_ram is a one-cycle pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_depth_nxt = r_depth;
    w_tos_nxt   = r_tos;
    w_op_nxt    = r_op;
    w_addr_nxt  = r_addr_ram;
    w_data_nxt  = r_data_ram;
    w_wren_nxt  = 1'b0;
    w_err_nxt   = r_err_code;

    case (r_state)
      ST_FETCH: begin
        if (run) w_state_nxt = ST_DECODE;
      end

      ST_DECODE: begin
        w_op_nxt = q_rom[7:0];
        if (is_binop(q_rom[7:0])) begin
          if (r_depth < DEPTH_W'(2)) begin
            w_state_nxt = ST_ERROR;
            w_err_nxt   = ERR_UNDERFLOW;
          end else begin
            w_addr_nxt  = w_nos_addr;
            w_state_nxt = ST_RD_WAIT;
          end
        end else begin
          case (q_rom[7:0])
            OP_HALT: w_state_nxt = ST_HALTED;
            OP_NOP: begin
              w_pc_nxt    = r_pc + ADDR_W'(1);
              w_state_nxt = ST_FETCH;
            end
            OP_DUP: begin
              if (r_depth == '0) begin
                w_state_nxt = ST_ERROR;
                w_err_nxt   = ERR_UNDERFLOW;
              end else if (r_depth == FULL) begin
                w_state_nxt = ST_ERROR;
                w_err_nxt   = ERR_OVERFLOW;
              end else begin
                w_addr_nxt  = w_top_addr;
                w_data_nxt  = r_tos;
                w_wren_nxt  = 1'b1;
                w_depth_nxt = r_depth + DEPTH_W'(1);
                w_pc_nxt    = r_pc + ADDR_W'(1);
                w_state_nxt = ST_FETCH;
              end
            end
            OP_IMM, OP_JMP: begin
              w_pc_nxt    = r_pc + ADDR_W'(1);
              w_state_nxt = ST_OP_WAIT;
            end
            OP_JZ: begin
              if (r_depth == '0) begin
                w_state_nxt = ST_ERROR;
                w_err_nxt   = ERR_UNDERFLOW;
              end else begin
                // Refill read overlaps the operand fetch.
                w_addr_nxt  = w_nos_addr;
                w_pc_nxt    = r_pc + ADDR_W'(1);
                w_state_nxt = ST_OP_WAIT;
              end
            end
            OP_DROP: begin
              if (r_depth == '0) begin
                w_state_nxt = ST_ERROR;
                w_err_nxt   = ERR_UNDERFLOW;
              end else begin
                w_addr_nxt  = w_nos_addr;
                w_state_nxt = ST_RD_WAIT;
              end
            end
            default: begin
              w_state_nxt = ST_ERROR;
              w_err_nxt   = ERR_ILLEGAL;
            end
          endcase
        end
      end

      ST_OP_WAIT: w_state_nxt = ST_OPERAND;

      ST_RD_WAIT: w_state_nxt = ST_EXEC;

      ST_OPERAND: begin
        w_state_nxt = ST_FETCH;
        case (r_op)
          OP_IMM: begin
            if (r_depth == FULL) begin
              w_state_nxt = ST_ERROR;
              w_err_nxt   = ERR_OVERFLOW;
            end else begin
              if (r_depth != '0) begin
                w_addr_nxt = w_top_addr;
                w_data_nxt = r_tos;
                w_wren_nxt = 1'b1;
              end
              w_tos_nxt   = q_rom;
              w_depth_nxt = r_depth + DEPTH_W'(1);
              w_pc_nxt    = r_pc + ADDR_W'(1);
            end
          end
          OP_JMP: w_pc_nxt = ADDR_W'(q_rom);
          OP_JZ: begin
            w_pc_nxt    = (r_tos == '0) ? ADDR_W'(q_rom) : (r_pc + ADDR_W'(1));
            w_tos_nxt   = q_ram;
            w_depth_nxt = r_depth - DEPTH_W'(1);
          end
          default: w_state_nxt = ST_FETCH;
        endcase
      end

      ST_EXEC: begin
        w_tos_nxt   = (r_op == OP_DROP) ? q_ram : w_alu;
        w_depth_nxt = r_depth - DEPTH_W'(1);
        w_pc_nxt    = r_pc + ADDR_W'(1);
        w_state_nxt = ST_FETCH;
      end

      ST_HALTED, ST_ERROR: w_state_nxt = r_state;

      default: w_state_nxt = ST_FETCH;
    endcase
  end

  assign address_rom = r_pc;
  assign pc          = r_pc;
  assign address_ram = r_addr_ram;
  assign data_ram    = r_data_ram;
  assign wren_ram    = r_wren;
  assign state       = r_state;
  assign depth       = r_depth;
  assign tos         = r_tos;
  assign halted      = (r_state == ST_HALTED);
  assign error       = (r_state == ST_ERROR);
  assign err_code    = r_err_code;

endmodule

// File: tb/tb_stack_core.sv
module tb_stack_core;
  import stack_core_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int SD = 4;
  localparam int SB = 0;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          run = 1'b0;
  logic [AW-1:0] address_rom, address_ram, pc;
  logic [DW-1:0] q_rom, q_ram, data_ram, tos;
  logic          wren_ram, halted, error;
  logic [3:0]    state;
  logic [2:0]    depth;
  logic [1:0]    err_code;

  logic [DW-1:0] rom [0:255];
  logic [DW-1:0] ram [0:255];
  int            wr_count = 0;
  int            wr_bad = 0;
  int            checks = 0;
  int            errors = 0;

  // reference model results
  logic [DW-1:0] m_stk[$];
  int m_cyc, m_pc, m_halt, m_err, m_code, m_wr;

  stack_core #(.DATA_W(DW), .ADDR_W(AW), .STACK_DEPTH(SD), .STACK_BASE(SB)) dut (
    .clock(clock), .reset_n(reset_n), .run(run),
    .address_rom(address_rom), .q_rom(q_rom),
    .address_ram(address_ram), .q_ram(q_ram), .data_ram(data_ram), .wren_ram(wren_ram),
    .pc(pc), .state(state), .depth(depth), .tos(tos),
    .halted(halted), .error(error), .err_code(err_code)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    q_rom <= rom[address_rom[7:0]];
    q_ram <= ram[address_ram[7:0]];
    if (wren_ram) begin
      ram[address_ram[7:0]] <= data_ram;
      wr_count++;
      if (halted || error) wr_bad++;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'h0000;
      ram[i] = 16'(32'hDEAD + i);
    end
  endtask

  task automatic start_prog();
    reset_n = 1'b0;
    run = 1'b1;
    @(negedge clock);
    @(negedge clock);
    wr_count = 0;
    wr_bad = 0;
    reset_n = 1'b1;
  endtask

  task automatic run_until_stop(input int budget, output int cyc);
    cyc = 0;
    while (!(halted || error) && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  // Instruction-level interpreter over the ROM image with a queue as the stack.
  task automatic model_run();
    int p, steps, done;
    logic [7:0] op;
    logic [DW-1:0] opd, a, b, t;
    p = 0; steps = 0; done = 0;
    m_cyc = 0; m_halt = 0; m_err = 0; m_code = 0; m_wr = 0;
    m_stk.delete();
    while (!done && steps < 500) begin
      steps++;
      op  = rom[p[7:0]][7:0];
      opd = rom[(p + 1) & 255];
      case (op)
        8'h00: begin m_cyc += 2; m_halt = 1; done = 1; end
        8'h18: begin m_cyc += 2; p = (p + 1) & 16'hFFFF; end
        8'h10: begin
          m_cyc += 2;
          if (m_stk.size() == 0) begin m_err = 1; m_code = 2; done = 1; end
          else if (m_stk.size() == SD) begin m_err = 1; m_code = 1; done = 1; end
          else begin m_wr++; m_stk.push_back(m_stk[$]); p = (p + 1) & 16'hFFFF; end
        end
        8'h01: begin
          m_cyc += 4;
          if (m_stk.size() == SD) begin m_err = 1; m_code = 1; done = 1; end
          else begin
            if (m_stk.size() >= 1) m_wr++;
            m_stk.push_back(opd);
            p = (p + 2) & 16'hFFFF;
          end
        end
        8'h06: begin m_cyc += 4; p = int'(opd); end
        8'h07: begin
          if (m_stk.size() == 0) begin m_cyc += 2; m_err = 1; m_code = 2; done = 1; end
          else begin
            m_cyc += 4;
            t = m_stk.pop_back();
            p = (t == 0) ? int'(opd) : ((p + 2) & 16'hFFFF);
          end
        end
        8'h0b, 8'h0c, 8'h0d, 8'h0e, 8'h0f: begin
          if (m_stk.size() < 2) begin m_cyc += 2; m_err = 1; m_code = 2; done = 1; end
          else begin
            m_cyc += 4;
            b = m_stk.pop_back();
            a = m_stk.pop_back();
            case (op)
              8'h0b:   m_stk.push_back(a + b);
              8'h0c:   m_stk.push_back(a - b);
              8'h0d:   m_stk.push_back(a & b);
              8'h0e:   m_stk.push_back(a | b);
              default: m_stk.push_back(a ^ b);
            endcase
            p = (p + 1) & 16'hFFFF;
          end
        end
        8'h11: begin
          if (m_stk.size() == 0) begin m_cyc += 2; m_err = 1; m_code = 2; done = 1; end
          else begin m_cyc += 4; void'(m_stk.pop_back()); p = (p + 1) & 16'hFFFF; end
        end
        default: begin m_cyc += 2; m_err = 1; m_code = 3; done = 1; end
      endcase
    end
    m_pc = p;
  endtask

  task automatic test_reset();
    int cyc;
    reset_n = 1'b0;
    run = 1'b1;
    clear_mem();
    @(negedge clock);
    checks++;
    if ({pc, depth, tos, wren_ram, address_ram, data_ram, err_code, halted, error} !== '0) begin
      errors++;
      $display("FAIL reset_init: pc=%h depth=%0d tos=%h wren=%b aram=%h dram=%h code=%0d h=%b e=%b (required all 0)",
               pc, depth, tos, wren_ram, address_ram, data_ram, err_code, halted, error);
    end
    checks++;
    if (state !== ST_FETCH) begin errors++; $display("FAIL reset_state: got %0d required %0d", state, ST_FETCH); end

    rom[0] = 16'h0001; rom[1] = 16'd3; rom[2] = 16'h0001; rom[3] = 16'd5; rom[4] = 16'h000b; rom[5] = 16'h0000;
    start_prog();
    repeat (10) @(negedge clock);
    checks++;
    if (state !== ST_RD_WAIT) begin errors++; $display("FAIL mid_state: got %0d required %0d", state, ST_RD_WAIT); end
    checks++;
    if (wr_count !== 1) begin errors++; $display("FAIL mid_writes: got %0d required 1", wr_count); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({pc, depth, tos, wren_ram, address_ram, data_ram, err_code, halted, error} !== '0 || state !== ST_FETCH) begin
      errors++;
      $display("FAIL async_reset: pc=%h st=%0d depth=%0d tos=%h wren=%b aram=%h dram=%h (required all 0)",
               pc, state, depth, tos, wren_ram, address_ram, data_ram);
    end
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (wr_count !== 1) begin errors++; $display("FAIL abort_write: got %0d writes required 1", wr_count); end
    reset_n = 1'b1;
    run_until_stop(100, cyc);
    checks++;
    if (cyc !== 14 || tos !== 16'd8 || !halted) begin
      errors++;
      $display("FAIL rerun: cyc=%0d tos=%h halted=%b required 14/0008/1", cyc, tos, halted);
    end
  endtask

  task automatic test_add_halt();
    int cyc;
    clear_mem();
    rom[0] = 16'h0001; rom[1] = 16'd3; rom[2] = 16'h0001; rom[3] = 16'd5; rom[4] = 16'h000b; rom[5] = 16'h0000;
    start_prog();
    run_until_stop(100, cyc);
    checks++;
    if (cyc !== 14) begin errors++; $display("FAIL add_cycles: got %0d required 14", cyc); end
    checks++;
    if (tos !== 16'd8 || depth !== 3'd1 || halted !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL add_result: tos=%h depth=%0d halted=%b error=%b required 0008/1/1/0", tos, depth, halted, error);
    end
    checks++;
    if (wr_count !== 1 || ram[0] !== 16'd3) begin
      errors++;
      $display("FAIL add_ram: writes=%0d ram0=%h required 1/0003", wr_count, ram[0]);
    end
  endtask

  task automatic test_sub();
    int cyc;
    clear_mem();
    rom[0] = 16'h0001; rom[1] = 16'd2; rom[2] = 16'h0001; rom[3] = 16'd7; rom[4] = 16'h000c; rom[5] = 16'h0000;
    start_prog();
    run_until_stop(100, cyc);
    checks++;
    if (tos !== 16'hFFFB || depth !== 3'd1 || !halted) begin
      errors++;
      $display("FAIL sub_result: tos=%h depth=%0d halted=%b required FFFB/1/1", tos, depth, halted);
    end
  endtask

  task automatic test_jz();
    int cyc;
    for (int v = 0; v < 2; v++) begin
      clear_mem();
      rom[0] = 16'h0001; rom[1] = 16'(v); rom[2] = 16'h0007; rom[3] = 16'h0010;
      rom[4] = 16'h0000; rom[16] = 16'h0000;
      start_prog();
      run_until_stop(100, cyc);
      checks++;
      if (pc !== ((v == 0) ? 16'h0010 : 16'h0004) || depth !== 3'd0 || !halted || cyc !== 10) begin
        errors++;
        $display("FAIL jz_imm%0d: pc=%h depth=%0d halted=%b cyc=%0d required %h/0/1/10",
                 v, pc, depth, halted, cyc, (v == 0) ? 16'h0010 : 16'h0004);
      end
    end
  endtask

  task automatic test_overflow();
    int cyc;
    clear_mem();
    for (int i = 0; i < 5; i++) begin
      rom[2*i] = 16'h0001;
      rom[2*i+1] = 16'(11 + i);
    end
    ram[3] = 16'hA5A5;
    start_prog();
    run_until_stop(100, cyc);
    checks++;
    if (!error || err_code !== ERR_OVERFLOW || depth !== 3'd4 || cyc !== 20) begin
      errors++;
      $display("FAIL overflow: error=%b code=%0d depth=%0d cyc=%0d required 1/1/4/20", error, err_code, depth, cyc);
    end
    checks++;
    if (ram[3] !== 16'hA5A5 || wr_count !== 3 || tos !== 16'd14 ||
        ram[0] !== 16'd11 || ram[1] !== 16'd12 || ram[2] !== 16'd13) begin
      errors++;
      $display("FAIL overflow_ram: ram=%h %h %h %h writes=%0d tos=%h required 000b 000c 000d a5a5/3/000e",
               ram[0], ram[1], ram[2], ram[3], wr_count, tos);
    end
  endtask

  task automatic test_errors();
    int cyc;
    clear_mem();
    rom[0] = 16'h000b;
    start_prog();
    run_until_stop(100, cyc);
    repeat (5) @(negedge clock);
    checks++;
    if (!error || halted || err_code !== ERR_UNDERFLOW || cyc !== 2 || wren_ram) begin
      errors++;
      $display("FAIL underflow: error=%b halted=%b code=%0d cyc=%0d required 1/0/2/2", error, halted, err_code, cyc);
    end
    clear_mem();
    rom[0] = 16'h0055;
    start_prog();
    run_until_stop(100, cyc);
    checks++;
    if (!error || err_code !== ERR_ILLEGAL) begin
      errors++;
      $display("FAIL illegal: error=%b code=%0d required 1/3", error, err_code);
    end
    clear_mem();
    reset_n = 1'b0;
    run = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (50) @(negedge clock);
    checks++;
    if (pc !== 16'h0000 || state !== ST_FETCH) begin
      errors++;
      $display("FAIL run_low: pc=%h state=%0d required 0000/%0d", pc, state, ST_FETCH);
    end
    run = 1'b1;
    run_until_stop(20, cyc);
    checks++;
    if (!halted || cyc !== 2) begin errors++; $display("FAIL run_resume: halted=%b cyc=%0d required 1/2", halted, cyc); end
  endtask

  task automatic test_random();
    int n, a, r, cyc;
    int kind [10];
    int addr [11];
    logic [7:0] hi, opc;
    logic [7:0] illegal [4];
    illegal[0] = 8'h02; illegal[1] = 8'h55; illegal[2] = 8'hFF; illegal[3] = 8'h12;
    for (int p = 0; p < 40; p++) begin
      clear_mem();
      for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
      n = $urandom_range(1, 10);
      a = 0;
      for (int k = 0; k < n; k++) begin
        r = $urandom_range(0, 15);
        if (r == 15 && $urandom_range(0, 3) != 0) r = 0;
        kind[k] = r;
        addr[k] = a;
        a += (r <= 4 || r == 13 || r == 14) ? 2 : 1;
      end
      addr[n] = a;
      for (int k = 0; k < n; k++) begin
        hi = 8'($urandom);
        case (kind[k])
          0, 1, 2, 3, 4: opc = 8'h01;
          5: opc = 8'h0b;  6: opc = 8'h0c;  7: opc = 8'h0d;  8: opc = 8'h0e;  9: opc = 8'h0f;
          10: opc = 8'h10; 11: opc = 8'h11; 12: opc = 8'h18; 13: opc = 8'h07; 14: opc = 8'h06;
          default: opc = illegal[$urandom_range(0, 3)];
        endcase
        rom[addr[k]] = {hi, opc};
        if (kind[k] <= 4)
          rom[addr[k] + 1] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 2)) : 16'($urandom);
        else if (kind[k] == 13 || kind[k] == 14)
          rom[addr[k] + 1] = 16'(addr[$urandom_range(k + 1, n)]);
      end
      model_run();
      start_prog();
      run_until_stop(400, cyc);
      checks++;
      if (cyc !== m_cyc) begin errors++; $display("FAIL rnd%0d_cycles: got %0d required %0d", p, cyc, m_cyc); end
      checks++;
      if (halted !== (m_halt == 1) || error !== (m_err == 1) || err_code !== 2'(m_code)) begin
        errors++;
        $display("FAIL rnd%0d_status: halted=%b error=%b code=%0d required %0d/%0d/%0d",
                 p, halted, error, err_code, m_halt, m_err, m_code);
      end
      checks++;
      if (depth !== 3'(m_stk.size())) begin
        errors++; $display("FAIL rnd%0d_depth: got %0d required %0d", p, depth, m_stk.size());
      end
      if (m_stk.size() > 0) begin
        checks++;
        if (tos !== m_stk[$]) begin errors++; $display("FAIL rnd%0d_tos: got %h required %h", p, tos, m_stk[$]); end
        for (int i = 0; i < m_stk.size() - 1; i++) begin
          checks++;
          if (ram[SB + i] !== m_stk[i]) begin
            errors++; $display("FAIL rnd%0d_ram%0d: got %h required %h", p, i, ram[SB + i], m_stk[i]);
          end
        end
      end
      if (m_halt == 1) begin
        checks++;
        if (pc !== 16'(m_pc)) begin errors++; $display("FAIL rnd%0d_pc: got %h required %h", p, pc, 16'(m_pc)); end
      end
      checks++;
      if (wr_count !== m_wr || wr_bad !== 0) begin
        errors++; $display("FAIL rnd%0d_writes: got %0d (stray %0d) required %0d", p, wr_count, wr_bad, m_wr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_halt();
    test_sub();
    test_jz();
    test_overflow();
    test_errors();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
